// File: rtl/power_013d_sweep_ctrl.sv
// power_013d_sweep_ctrl: sweeps the 4-input power_013d sub-circuit over all vectors (binary/Gray order) and counts output ones and toggles
module power_013d_sweep_ctrl #(
  parameter int REPEAT = 1,
  parameter int SETTLE = 1,
  parameter int CNT_W = 12
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic             gray_mode,
  input  logic             fn_out,
  output logic [3:0]       vec,
  output logic             sample_stb,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] ones_cnt,
  output logic [CNT_W-1:0] toggle_cnt
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t st;
  logic [3:0] idx, hold;
  logic [7:0] sweep;
  logic gray, have_prev, prev, last;
  assign sample_stb = st == RUN && hold == 4'(SETTLE - 1);
  assign last = idx == 4'd15 && sweep == 8'(REPEAT - 1);
  assign vec = st != RUN ? 4'd0 : gray ? idx ^ (idx >> 1) : idx;
  always_ff @(posedge clk) begin
    if (rst) begin
      st <= IDLE;
      busy <= 1'b0;
      done <= 1'b0;
      idx <= '0;
      hold <= '0;
      sweep <= '0;
      gray <= 1'b0;
      have_prev <= 1'b0;
      prev <= 1'b0;
      ones_cnt <= '0;
      toggle_cnt <= '0;
    end else begin
      case (st)
        IDLE: if (start && !abort) begin
          st <= RUN;
          busy <= 1'b1;
          ones_cnt <= '0;
          toggle_cnt <= '0;
          have_prev <= 1'b0;
          gray <= gray_mode;
          idx <= '0;
          hold <= '0;
          sweep <= '0;
        end
        RUN: if (abort) begin
          st <= IDLE;
          busy <= 1'b0;
        end else if (!sample_stb) begin
          hold <= hold + 4'd1;
        end else begin
          hold <= '0;
          ones_cnt <= (fn_out && ones_cnt != '1) ? ones_cnt + CNT_W'(1) : ones_cnt;
          toggle_cnt <= (have_prev && fn_out != prev && toggle_cnt != '1) ? toggle_cnt + CNT_W'(1) : toggle_cnt;
          prev <= fn_out;
          have_prev <= 1'b1;
          idx <= idx + 4'd1;
          sweep <= idx == 4'd15 ? sweep + 8'd1 : sweep;
          if (last) begin
            st <= DONE;
            busy <= 1'b0;
            done <= 1'b1;
          end
        end
        DONE: begin
          st <= IDLE;
          done <= 1'b0;
        end
        default: st <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_power_013d_sweep_ctrl.sv
// tb_power_013d_sweep_ctrl: self-checking bench for power_013d_sweep_ctrl across three parameter sets
module tb_power_013d_sweep_ctrl;
  logic clk = 0, rst = 1, start = 0, abort = 0, gray_mode = 0;
  logic [3:0] v1, v2, v3;
  logic s1, s2, s3, b1, b2, b3, d1, d2, d3, f1, f2, f3;
  logic [11:0] o1, t1, o2, t2;
  logic [2:0] o3, t3;
  int pass_n = 0, total_n = 0;
  typedef struct {bit g; int o1; int t1; int o2; int t2; int o3; int t3;} vec_t;
  vec_t tbl[2];
  logic [3:0] gseq[16] = '{0, 1, 3, 2, 6, 7, 5, 4, 12, 13, 15, 14, 10, 11, 9, 8};
  always #5 clk = ~clk;
  function automatic logic golden(input logic [3:0] v);
    return (v[0] & v[2]) ^ (v[1] & (v[0] ^ (v[2] & v[3])));
  endfunction
  assign f1 = golden(v1);
  assign f2 = golden(v2);
  assign f3 = golden(v3);
  power_013d_sweep_ctrl #(.REPEAT(1), .SETTLE(1), .CNT_W(12)) u1 (.clk(clk), .rst(rst), .start(start), .abort(abort),
    .gray_mode(gray_mode), .fn_out(f1), .vec(v1), .sample_stb(s1), .busy(b1), .done(d1), .ones_cnt(o1), .toggle_cnt(t1));
  power_013d_sweep_ctrl #(.REPEAT(2), .SETTLE(3), .CNT_W(12)) u2 (.clk(clk), .rst(rst), .start(start), .abort(abort),
    .gray_mode(gray_mode), .fn_out(f2), .vec(v2), .sample_stb(s2), .busy(b2), .done(d2), .ones_cnt(o2), .toggle_cnt(t2));
  power_013d_sweep_ctrl #(.REPEAT(2), .SETTLE(1), .CNT_W(3)) u3 (.clk(clk), .rst(rst), .start(start), .abort(abort),
    .gray_mode(gray_mode), .fn_out(f3), .vec(v3), .sample_stb(s3), .busy(b3), .done(d3), .ones_cnt(o3), .toggle_cnt(t3));
  task automatic chk(input string nm, input int act, input int exp);
    total_n++;
    if (act == exp) pass_n++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask
  // Reference: walk the visit order, evaluate the golden function, count and clamp.
  task automatic model(input bit g, input int n, input int maxv, output int o, output int t);
    int p = 0;
    o = 0;
    t = 0;
    for (int k = 0; k < n; k++) begin
      int i = k % 16;
      int s = int'(golden(4'(g ? (i ^ (i >> 1)) : i)));
      o += s;
      if (k > 0 && s != p) t++;
      p = s;
    end
    if (o > maxv) o = maxv;
    if (t > maxv) t = maxv;
  endtask
  task automatic chk_quiet(input string tag);
    chk({tag, " u1 outs"}, int'({b1, d1, s1, v1}), 0);
    chk({tag, " u2 outs"}, int'({b2, d2, s2, v2}), 0);
    chk({tag, " u3 outs"}, int'({b3, d3, s3, v3}), 0);
  endtask
  task automatic launch(input bit g);
    @(posedge clk); #1;
    start = 1;
    gray_mode = g;
    @(posedge clk); #1;
    start = 0;
    chk("busy after accept", int'({b1, b2, b3}), 7);
  endtask
  task automatic cleanup();
    @(posedge clk); #1;
    abort = 1;
    @(posedge clk); #1;
    abort = 0;
    @(posedge clk); #1;
  endtask
  task automatic full_run(input vec_t r);
    int c1 = -1, c2 = -1, c3 = -1;
    launch(r.g);
    chk("first vec", int'(v1), 0);
    for (int c = 1; c <= 120 && (c1 < 0 || c2 < 0 || c3 < 0); c++) begin
      @(posedge clk); #1;
      if (c < 16) chk("u1 vec order", int'(v1), int'(r.g ? gseq[c] : 4'(c)));
      if (c < 9) chk("u2 stb phase", int'(s2), int'(c % 3 == 2));
      if (c == 17) chk("u1 done one cycle", int'({d1, b1}), 0);
      if (d1 && c1 < 0) c1 = c;
      if (d2 && c2 < 0) c2 = c;
      if (d3 && c3 < 0) c3 = c;
    end
    chk("u1 done edge", c1, 16);
    chk("u2 done edge", c2, 96);
    chk("u3 done edge", c3, 32);
    chk("u1 ones", int'(o1), r.o1);
    chk("u1 toggles", int'(t1), r.t1);
    chk("u2 ones", int'(o2), r.o2);
    chk("u2 toggles", int'(t2), r.t2);
    chk("u3 ones sat", int'(o3), r.o3);
    chk("u3 toggles sat", int'(t3), r.t3);
  endtask
  task automatic abort_run(input bit g, input int k);
    int eo, et;
    launch(g);
    repeat (k) @(posedge clk);
    #1;
    abort = 1;
    @(posedge clk); #1;
    abort = 0;
    chk("abort to idle", int'({b1, b2, b3}), 0);
    for (int c = 0; c < 3; c++) begin
      chk("no done after abort", int'({d1, d2, d3}), 0);
      @(posedge clk); #1;
    end
    model(g, k, 4095, eo, et);
    chk("abort u1 ones", int'(o1), eo);
    chk("abort u1 toggles", int'(t1), et);
    model(g, k / 3, 4095, eo, et);
    chk("abort u2 ones", int'(o2), eo);
    chk("abort u2 toggles", int'(t2), et);
    model(g, k, 7, eo, et);
    chk("abort u3 ones", int'(o3), eo);
    chk("abort u3 toggles", int'(t3), et);
  endtask
  initial begin
    int nd;
    tbl[0] = '{g: 0, o1: 6, t1: 7, o2: 12, t2: 15, o3: 7, t3: 7};
    tbl[1] = '{g: 1, o1: 6, t1: 8, o2: 12, t2: 16, o3: 7, t3: 7};
    repeat (2) @(posedge clk);
    #1;
    chk_quiet("reset");
    chk("reset counters", int'({o1, t1, o2, t2, o3, t3}), 0);
    rst = 0;
    for (int k = 0; k < 2; k++) full_run(tbl[k]);
    launch(0);
    repeat (4) @(posedge clk);
    #1;
    chk("5th strobe active", int'(s1), 1);
    abort = 1;
    @(posedge clk); #1;
    abort = 0;
    chk("abort idle", int'({b1, d1, v1}), 0);
    chk("abort ones", int'(o1), 1);
    chk("abort toggles", int'(t1), 1);
    launch(0);
    chk("restart clears", int'({o1, t1}), 0);
    cleanup();
    for (int n = 0; n < 8; n++) abort_run(1'($urandom_range(0, 1)), int'($urandom_range(0, 15)));
    launch(1);
    repeat (5) @(posedge clk);
    #1;
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
    chk_quiet("mid-run reset");
    chk("mid-run reset counters", int'({o1, t1, o2, t2, o3, t3}), 0);
    @(posedge clk); #1;
    start = 1;
    gray_mode = 0;
    @(posedge clk); #1;
    nd = 0;
    for (int c = 1; c <= 18; c++) begin
      @(posedge clk); #1;
      nd += int'(d1);
      if (c == 17) chk("held start idle gap", int'(b1), 0);
      if (c == 18) chk("held start reaccept", int'(b1), 1);
    end
    chk("held start one done", nd, 1);
    start = 0;
    cleanup();
    start = 1;
    abort = 1;
    @(posedge clk); #1;
    start = 0;
    abort = 0;
    chk_quiet("start+abort idle");
    $display("%0d/%0d checks passed", pass_n, total_n);
    $finish;
  end
endmodule

// File: doc/power_013d_sweep_ctrl.md
# power_013d_sweep_ctrl

Sequencer that drives the 4-input power_013d sub-circuit through every input vector, in binary or Gray order, and measures its output activity. It latches the sub-circuit output per vector and reports the count of 1s and the count of output toggles. The power characterization flow uses these numbers as the switching-activity reference for rewritten variants. The sub-circuit sits outside this block: `vec` drives its inputs and `fn_out` is its output.

## Interface
- `REPEAT`, default 1: number of full 16-vector sweeps per run, range 1..255.
- `SETTLE`, default 1: cycles each vector is held, range 1..15. `fn_out` is sampled on the last held cycle.
- `CNT_W`, default 12: width of the result counters.

Ports:
- `clk`  in  1: sole clock; all state changes on the rising edge.
- `rst`  in  1: synchronous reset, active-high.
- `start`  in  1: run request; sampled only in IDLE.
- `abort`  in  1: terminate a run; sampled in RUN.
- `gray_mode`  in  1: 0 = binary order, 1 = Gray order; latched on `start` acceptance.
- `fn_out`  in  1: sub-circuit output (n_9), combinational from `vec`.
- `vec`  out  4: sub-circuit inputs; `vec[0]`=n_1, `vec[1]`=n_2, `vec[2]`=n_3, `vec[3]`=n_4.
- `sample_stb`  out  1: high in the cycle whose closing edge samples `fn_out`.
- `busy`  out  1: high while in RUN.
- `done`  out  1: one-cycle pulse on normal completion.
- `ones_cnt`  out  CNT_W: number of samples equal to 1.
- `toggle_cnt`  out  CNT_W: number of samples differing from the previous sample in the same run.

## Operation
- States: IDLE, RUN, DONE.
- IDLE:
  - `vec`=0.
  - `start`=1 and `abort`=0: clear both counters, clear the "have previous sample" flag, latch `gray_mode`, load index i=0, hold counter=0, sweep counter=0, go to RUN.
  - `start` with `abort` in the same cycle: stay in IDLE.
- RUN:
  - `vec` = i in binary mode; `vec` = i ^ (i>>1) in Gray mode.
  - Each vector is held SETTLE cycles. `sample_stb` is high on the last of those cycles.
  - On the sampling edge:
    - `ones_cnt` += `fn_out`.
    - If the previous-sample flag is set and `fn_out` ≠ previous sample, `toggle_cnt` += 1.
    - Store the previous sample and set the flag.
    - Advance i, wrapping 15→0. On wrap, increment the sweep counter.
  - The previous sample carries across sweeps, so the transition from the last vector of one sweep to the first vector of the next is counted.
  - The sample of vector 15 in sweep REPEAT-1 is the final sample. The same edge moves the FSM to DONE.
  - `start` is ignored in RUN.
  - `abort`=1: go to IDLE on that edge. No sample is taken on that edge, even if `sample_stb` was high. `done` is not pulsed and the counters keep their partial values.
- DONE: `done`=1 and `vec`=0 for one cycle, then IDLE. `start` is ignored in DONE.
- Counters saturate at 2^CNT_W−1; they never wrap.
- Counters hold their values in IDLE and DONE until the next accepted `start` or `rst`.
- `rst` in any state, including mid-run: on that edge, state=IDLE, `vec`=0, `busy`=0, `done`=0, `sample_stb`=0, counters=0, latched mode=0, previous-sample flag cleared.

## Timing
- `start` accepted at edge E:
  - `busy`=1 and `vec`=first vector from E.
  - Sample n (0-based) is taken at edge E+(n+1)·SETTLE.
  - The final sample is at edge E+16·REPEAT·SETTLE. From that edge, `busy`=0 and `done`=1 for one cycle.
- Back-to-back operation: the earliest next accept is the edge after the DONE cycle. The IDLE gap is ≥1 cycle.
- `fn_out` needs only to settle within one cycle of a `vec` change. The SETTLE>1 setting exists for glitch/power observation, not for correctness.
- Counters are final and stable in the cycle where `done`=1.
- All outputs are registered, except that `vec` and `sample_stb` are decoded directly from state registers.

## Test plan
- Golden model: n_9 = (n_1&n_3) ^ (n_2&(n_1^(n_3&n_4))).
  - Binary output sequence for i=0..15: 0,0,0,1,0,1,0,0,0,0,0,1,0,1,1,1.
- Binary sweep, REPEAT=1, SETTLE=1: start at E -> `vec` steps 0..15 over edges E..E+15, `done` at E+16, `ones_cnt`=6, `toggle_cnt`=7.
- Gray sweep, REPEAT=1: `vec` sequence 0,1,3,2,6,7,5,4,12,13,15,14,10,11,9,8 -> `ones_cnt`=6, `toggle_cnt`=8.
- REPEAT=2, SETTLE=3: binary -> `ones_cnt`=12, `toggle_cnt`=15 (includes the sweep-boundary toggle), `done` at E+96. Gray -> `ones_cnt`=12, `toggle_cnt`=16.
- `abort` raised at the 5th sample-strobe cycle (binary) -> IDLE next edge, no `done`, `ones_cnt`=1, `toggle_cnt`=1. A subsequent `start` clears the counters.
- `rst` mid-run, `start` held high through RUN, and `start`+`abort` together in IDLE:
  - `rst` mid-run -> all outputs 0 on the next edge.
  - `start` held through RUN -> no restart; exactly one `done`, then a new run accepted on the edge after DONE.
  - `start`+`abort` in IDLE -> stays in IDLE.
- CNT_W=3, REPEAT=2 -> `ones_cnt` saturates at 7 (true value 12); `toggle_cnt` saturates at 7.
